// File: rtl/mas_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : mas_mul_arb
// Purpose  : Shares one registered multiplier among NREQ requesters and routes
//            each product back through a latency-matched tag pipeline.
// Config   : MAS_MUL_ARB_RR_EN defined -> round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mas_mul_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 flush,
    output logic [31:0]          mul_in1,
    output logic [31:0]          mul_in2,
    input  logic [63:0]          mul_res,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [63:0]          rsp_data,
    output logic                 busy
);
    localparam int              c_IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_NSTG = 1 + LAT;
    localparam logic [NREQ-1:0] c_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    logic [NREQ-1:0]              w_valid;
    logic [NREQ-1:0]              w_grant;
    logic                         w_grant_any;
    logic [c_IDW-1:0]             w_gid;
    logic [NREQ:0][c_IDW-1:0]     w_id_acc;
    logic [NREQ:0][31:0]          w_a_acc;
    logic [NREQ:0][31:0]          w_b_acc;
    logic [c_NSTG-1:0]            r_vld;
    logic [c_NSTG-1:0][c_IDW-1:0] r_id;

    // Nothing may be granted during a flush cycle.
    assign w_valid = flush ? '0 : req_valid;

`ifdef MAS_MUL_ARB_RR_EN
    localparam logic [c_IDW:0]   c_NREQ_W = (c_IDW+1)'(NREQ);
    localparam logic [c_IDW-1:0] c_LAST   = c_IDW'(NREQ - 1);
    localparam logic [c_IDW-1:0] c_ID_ONE = c_IDW'(1);

    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW:0]   w_back;
    logic [NREQ-1:0]  w_rot;
    logic [NREQ-1:0]  w_rot_oh;

    // Rotate so that ptr sits at bit 0, isolate lowest set bit, rotate back.
    assign w_back   = c_NREQ_W - {1'b0, r_ptr};
    assign w_rot    = (w_valid >> r_ptr) | (w_valid << w_back);
    assign w_rot_oh = w_rot & ~(w_rot - c_ONE);
    assign w_grant  = (w_rot_oh << r_ptr) | (w_rot_oh >> w_back);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= (w_gid == c_LAST) ? '0 : w_gid + c_ID_ONE;
        end
    end
`else
    assign w_grant = w_valid & ~(w_valid - c_ONE);
`endif

    assign req_ready   = w_grant;
    assign w_grant_any = |w_grant;

    // One-hot grant drives an OR-chain encoder and operand mux.
    assign w_id_acc[0] = '0;
    assign w_a_acc[0]  = '0;
    assign w_b_acc[0]  = '0;
    for (genvar i = 0; i < NREQ; i++) begin : g_sel
        assign w_id_acc[i+1] = w_id_acc[i] | (w_grant[i] ? c_IDW'(i) : '0);
        assign w_a_acc[i+1]  = w_a_acc[i]  | (w_grant[i] ? req_a[32*i +: 32] : 32'd0);
        assign w_b_acc[i+1]  = w_b_acc[i]  | (w_grant[i] ? req_b[32*i +: 32] : 32'd0);
    end
    assign w_gid = w_id_acc[NREQ];

    // Operands hold when idle to keep the multiplier quiet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_in1 <= '0;
            mul_in2 <= '0;
        end else if (w_grant_any) begin
            mul_in1 <= w_a_acc[NREQ];
            mul_in2 <= w_b_acc[NREQ];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld <= flush ? '0 : {r_vld[c_NSTG-2:0], w_grant_any};
            r_id  <= {r_id[c_NSTG-2:0], w_gid};
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_valid[i] = r_vld[c_NSTG-1] & (r_id[c_NSTG-1] == c_IDW'(i));
    end

    assign rsp_data = mul_res;
    assign busy     = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_mas_mul_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mas_mul_arb
// Purpose  : Randomized self-checking bench for mas_mul_arb with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mas_mul_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic                clk  = 1'b0;
    logic                rstn = 1'b1;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                flush;
    logic [31:0]         mul_in1;
    logic [31:0]         mul_in2;
    logic [63:0]         mul_res = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_data;
    logic                busy;

    mas_mul_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .flush     (flush),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_res   (mul_res),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the single-cycle registered multiplier.
    always @(posedge clk) mul_res <= {32'b0, mul_in1} * {32'b0, mul_in2};

    typedef struct {
        int          due;
        int          id;
        logic [63:0] prod;
    } rsp_t;

    int          total = 0;
    int          bad   = 0;
    int          m_ptr = 0;
    int          m_cyc = 0;
    logic [31:0] m_in1 = '0;
    logic [31:0] m_in2 = '0;
    rsp_t        pend[$];
    logic [31:0] a_q[NREQ];
    logic [31:0] b_q[NREQ];

`ifdef MAS_MUL_ARB_RR_EN
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
`else
    int exp_order[6] = '{0, 0, 0, 0, 0, 1};
`endif

    function automatic int model_grant(input logic [NREQ-1:0] v, input logic f);
        int idx;
        if (f) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic f);
        req_valid = v;
        flush     = f;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = a_q[i];
            req_b[32*i +: 32] = b_q[i];
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_ptr = 0;
        m_in1 = '0;
        m_in2 = '0;
    endtask

    task automatic expect_now(output logic [NREQ-1:0] e_ready, output logic [NREQ-1:0] e_rv,
                              output logic [63:0] e_rd, output logic e_busy);
        int g;
        g       = model_grant(req_valid, flush);
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rv   = '0;
        e_rd   = '0;
        e_busy = 1'b0;
        foreach (pend[k]) begin
            if (pend[k].due == m_cyc) begin
                e_rv[pend[k].id] = 1'b1;
                e_rd             = pend[k].prod;
            end
            if (pend[k].due >= m_cyc) e_busy = 1'b1;
        end
    endtask

    // Advances the model across the coming clock edge.
    task automatic commit();
        int   g;
        rsp_t keep[$];
        g = model_grant(req_valid, flush);
        if (g >= 0) begin
            pend.push_back('{m_cyc + 1 + LAT, g,
                             {32'b0, req_a[32*g +: 32]} * {32'b0, req_b[32*g +: 32]}});
            m_in1 = req_a[32*g +: 32];
            m_in2 = req_b[32*g +: 32];
`ifdef MAS_MUL_ARB_RR_EN
            m_ptr = (g + 1) % NREQ;
`endif
        end
        if (!flush) begin
            foreach (pend[k]) if (pend[k].due > m_cyc) keep.push_back(pend[k]);
        end
        pend  = keep;
        m_cyc = m_cyc + 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_q[i] = '0;
            b_q[i] = '0;
        end
        drive('0, 1'b0);
        #1 rstn = 1'b0;
        #2;
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset ready: got %b want 0", req_ready); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (mul_in1 !== 32'd0 || mul_in2 !== 32'd0) begin bad++; $display("FAIL reset mul_in: got %h %h want 0 0", mul_in1, mul_in2); end
        total++; if (rsp_data !== mul_res) begin bad++; $display("FAIL reset rsp_data: got %h want %h", rsp_data, mul_res); end
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_arbitration();
        logic [NREQ-1:0] e_ready, e_rv, v;
        logic [63:0]     e_rd;
        logic            e_busy;
        int              g;
        for (int i = 0; i < NREQ; i++) begin
            a_q[i] = $urandom;
            b_q[i] = $urandom;
        end
        for (int c = 0; c < 9; c++) begin
            v = (c < 5) ? 4'b1111 : (c == 5) ? 4'b1110 : 4'b0000;
            drive(v, 1'b0);
            @(negedge clk);
            expect_now(e_ready, e_rv, e_rd, e_busy);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL arb ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL arb rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); end
            if (e_rv != '0) begin
                total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL arb rsp_data c=%0d: got %h want %h", c, rsp_data, e_rd); end
            end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL arb busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (mul_in1 !== m_in1 || mul_in2 !== m_in2) begin bad++; $display("FAIL arb mul_in c=%0d: got %h %h want %h %h", c, mul_in1, mul_in2, m_in1, m_in2); end
            if (c < 6) begin
                total++; if (req_ready !== (4'b0001 << exp_order[c])) begin bad++; $display("FAIL arb order c=%0d: got %b want %b", c, req_ready, 4'b0001 << exp_order[c]); end
            end
            g = model_grant(req_valid, flush);
            commit();
            if (g >= 0) begin
                a_q[g] = $urandom;
                b_q[g] = $urandom;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_and_max();
        logic [NREQ-1:0] e_ready, e_rv, v;
        logic [63:0]     e_rd;
        logic            e_busy;
        a_q[2] = 32'd3;
        b_q[2] = 32'd5;
        a_q[1] = 32'hFFFF_FFFF;
        b_q[1] = 32'hFFFF_FFFF;
        for (int c = 0; c < 8; c++) begin
            v = (c == 0) ? 4'b0100 : (c == 3) ? 4'b0010 : 4'b0000;
            drive(v, 1'b0);
            @(negedge clk);
            expect_now(e_ready, e_rv, e_rd, e_busy);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL single ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL single rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); end
            if (e_rv != '0) begin
                total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL single rsp_data c=%0d: got %h want %h", c, rsp_data, e_rd); end
            end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL single busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (mul_in1 !== m_in1 || mul_in2 !== m_in2) begin bad++; $display("FAIL single mul_in c=%0d: got %h %h want %h %h", c, mul_in1, mul_in2, m_in1, m_in2); end
            if (c == 1) begin
                total++; if (busy !== 1'b1 || mul_in1 !== 32'd3 || mul_in2 !== 32'd5) begin bad++; $display("FAIL single t1: got busy=%b in=%h %h want 1 3 5", busy, mul_in1, mul_in2); end
            end
            if (c == 2) begin
                total++; if (rsp_valid !== 4'b0100 || rsp_data !== 64'd15 || busy !== 1'b1) begin bad++; $display("FAIL single t2: got %b %h busy=%b want 0100 15 1", rsp_valid, rsp_data, busy); end
            end
            if (c == 3) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single t3 busy: got %b want 0", busy); end
            end
            if (c == 5) begin
                total++; if (rsp_valid !== 4'b0010 || rsp_data !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL max product: got %b %h want 0010 fffffffe00000001", rsp_valid, rsp_data); end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic [NREQ-1:0] e_ready, e_rv, v;
        logic [63:0]     e_rd;
        logic            e_busy;
        for (int i = 0; i < NREQ; i++) begin
            a_q[i] = rnd_op();
            b_q[i] = rnd_op();
        end
        for (int c = 0; c < 6; c++) begin
            v = (c == 0) ? 4'b0010 : (c == 1) ? 4'b1000 : (c == 2) ? 4'b0001 : 4'b0000;
            drive(v, c == 2);
            @(negedge clk);
            expect_now(e_ready, e_rv, e_rd, e_busy);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL flush ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL flush rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); end
            if (e_rv != '0) begin
                total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL flush rsp_data c=%0d: got %h want %h", c, rsp_data, e_rd); end
            end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL flush busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (mul_in1 !== m_in1 || mul_in2 !== m_in2) begin bad++; $display("FAIL flush mul_in c=%0d: got %h %h want %h %h", c, mul_in1, mul_in2, m_in1, m_in2); end
            if (c == 2) begin
                total++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0010) begin bad++; $display("FAIL flush cycle: got ready=%b rsp=%b want 0000 0010", req_ready, rsp_valid); end
            end
            if (c >= 3) begin
                total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL flush dropped c=%0d: got %b want 0000", c, rsp_valid); end
            end
            if (c == 4) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush busy after: got %b want 0", busy); end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] e_ready, e_rv;
        logic [NREQ-1:0] pv;
        logic [63:0]     e_rd;
        logic            e_busy;
        int              g;
        pv = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1'b1;
                    a_q[i] = rnd_op();
                    b_q[i] = rnd_op();
                end else if (pv[i] && $urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            drive(pv, $urandom_range(0, 19) == 0);
            @(negedge clk);
            expect_now(e_ready, e_rv, e_rd, e_busy);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rand ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL rand rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); end
            if (e_rv != '0) begin
                total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL rand rsp_data c=%0d: got %h want %h", c, rsp_data, e_rd); end
            end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL rand busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (mul_in1 !== m_in1 || mul_in2 !== m_in2) begin bad++; $display("FAIL rand mul_in c=%0d: got %h %h want %h %h", c, mul_in1, mul_in2, m_in1, m_in2); end
            g = model_grant(req_valid, flush);
            commit();
            if (g >= 0) pv[g] = 1'b0;
            @(posedge clk); #1;
        end
        drive('0, 1'b0);
        repeat (3) begin
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] e_ready, e_rv, v;
        logic [63:0]     e_rd;
        logic            e_busy;
        for (int i = 0; i < NREQ; i++) begin
            a_q[i] = rnd_op();
            b_q[i] = rnd_op();
        end
        for (int c = 0; c < 9; c++) begin
            if (c == 3) begin
                drive('0, 1'b0);
                #2 rstn = 1'b0;
                #1;
                total++; if (rsp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL midreset clear: got rsp=%b busy=%b want 0 0", rsp_valid, busy); end
                total++; if (mul_in1 !== 32'd0 || mul_in2 !== 32'd0) begin bad++; $display("FAIL midreset mul_in: got %h %h want 0 0", mul_in1, mul_in2); end
                model_reset();
                @(posedge clk); #1;
                @(posedge clk); #1;
                rstn = 1'b1;
            end
            v = (c < 3) ? (4'b0010 << c) : (c == 3) ? 4'b1111 : 4'b0000;
            drive(v, 1'b0);
            @(negedge clk);
            expect_now(e_ready, e_rv, e_rd, e_busy);
            total++; if (req_ready !== e_ready) begin bad++; $display("FAIL midreset ready c=%0d: got %b want %b", c, req_ready, e_ready); end
            total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL midreset rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); end
            if (e_rv != '0) begin
                total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL midreset rsp_data c=%0d: got %h want %h", c, rsp_data, e_rd); end
            end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL midreset busy c=%0d: got %b want %b", c, busy, e_busy); end
            total++; if (mul_in1 !== m_in1 || mul_in2 !== m_in2) begin bad++; $display("FAIL midreset mul_in c=%0d: got %h %h want %h %h", c, mul_in1, mul_in2, m_in1, m_in2); end
            if (c == 3) begin
                total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midreset first grant: got %b want 0001", req_ready); end
            end
            if (c == 4) begin
                total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL midreset stale rsp: got %b want 0000", rsp_valid); end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_and_max();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
